fht_control_gen: RTL and testbench

Parametrised sequencer for the in-place radix-2 FHT core: N = 2^N_LOG2 points spread over 4 bank RAMs of depth D = 2^A_BIT, with A_BIT = N_LOG2-2. It generates stage and sector timing, the direct and Hartley-mirror read addresses, delayed write addresses and strobes, twiddle coefficient addresses, and ping-pong source selects for the bank mixers. Compared with the fixed 1024-point controller, it adds:
- generic size;
- configurable butterfly latency;
- an abort input;
- a busy/done handshake.

---
 rtl/fht_pkg.sv | 41 ++++
 rtl/fht_addr_map.sv | 47 ++++
 rtl/fht_control_gen.sv | 169 ++++++++++++++++
 tb/tb_fht_control_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared sizing and address helpers for the parametrised FHT sequencer.
// Sector length for stage s is D >> (s-1). It is kept as a shift count so the address maps stay power-of-two masks.
package fht_pkg;

  localparam int N_LOG2_DEF   = 10;
  localparam int BFLY_LAT_DEF = 6;

  typedef enum logic {FHT_IDLE = 1'b0, FHT_RUN = 1'b1} fht_state_t;

  function automatic int depth(input int n_log2);
    return 1 << (n_log2 - 2);
  endfunction

  function automatic int stage_len(input int n_log2, input int bfly_lat);
    return 2 * depth(n_log2) + bfly_lat;
  endfunction

  // Sector length is 1 << (a_bit - shift); the shift saturates so the length floors at 1.
  function automatic int sector_shift(input int stage, input int a_bit);
    int sh;
    if (stage == 0) sh = 0;
    else sh = stage - 1;
    if (sh > a_bit) sh = a_bit;
    return sh;
  endfunction

  function automatic int mirror_addr(input int p, input int sh, input int a_bit);
    int lg;
    int mask;
    lg   = a_bit - sh;
    mask = (1 << lg) - 1;
    if ((p >> lg) == 0) return p;
    return (p & ~mask) | ((-(p & mask)) & mask);
  endfunction

  function automatic int coef_idx(input int o, input int stage, input int a_bit);
    if (stage == 0) return 0;
    return (o << (stage - 1)) & ((1 << a_bit) - 1);
  endfunction

endpackage

// File: rtl/fht_addr_map.sv
// Maps a butterfly step index and stage to sector, direct/mirror bank addresses and twiddle index.
module fht_addr_map
  import fht_pkg::*;
#(
  parameter int A_BIT   = 8,
  parameter int SEC_BIT = 9,
  parameter int ST_BIT  = 4
) (
  input  logic [A_BIT-1:0]   step,
  input  logic [ST_BIT-1:0]  stage,
  input  logic               en,
  output logic [SEC_BIT-1:0] sector,
  output logic               second_half,
  output logic [A_BIT-1:0]   direct,
  output logic [A_BIT-1:0]   mirror,
  output logic [A_BIT-1:0]   coef
);

  int sh;
  int lg;
  int mask;
  int k;
  int o;

  // Split the step into sector/offset and derive all addresses; zero outside the active window.
  always_comb begin
    sh   = sector_shift(int'(stage), A_BIT);
    lg   = A_BIT - sh;
    mask = (1 << lg) - 1;
    k    = int'(step) >> lg;
    o    = int'(step) & mask;
    if (en) begin
      sector      = SEC_BIT'(k);
      second_half = (o >= ((mask + 1) >> 1));
      direct      = step;
      mirror      = A_BIT'(mirror_addr(int'(step), sh, A_BIT));
      coef        = A_BIT'(coef_idx(o, int'(stage), A_BIT));
    end else begin
      sector      = {SEC_BIT{1'b0}};
      second_half = 1'b0;
      direct      = {A_BIT{1'b0}};
      mirror      = {A_BIT{1'b0}};
      coef        = {A_BIT{1'b0}};
    end
  end

endmodule

// File: rtl/fht_control_gen.sv
// Stage/sector sequencer for the in-place radix-2 FHT: read and delayed write addressing,
// write strobes, twiddle addresses and ping-pong bank selection, with abort and busy/done handshake.
module fht_control_gen
  import fht_pkg::*;
#(
  parameter  int N_LOG2   = N_LOG2_DEF,
  localparam int A_BIT    = N_LOG2 - 2,
  parameter  int SEC_BIT  = N_LOG2 - 1,
  parameter  int ST_BIT   = 4,
  parameter  int BFLY_LAT = BFLY_LAT_DEF
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic               iABORT,
  output logic [ST_BIT-1:0]  oSTAGE,
  output logic               oST_ZERO,
  output logic               oST_LAST,
  output logic               o2ND_PART_SUBSEC,
  output logic [SEC_BIT-1:0] oSECTOR,
  output logic [A_BIT-1:0]   oADDR_RD_0,
  output logic [A_BIT-1:0]   oADDR_RD_1,
  output logic [A_BIT-1:0]   oADDR_RD_2,
  output logic [A_BIT-1:0]   oADDR_RD_3,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [A_BIT-1:0]   oADDR_WR_BIAS,
  output logic [A_BIT-1:0]   oADDR_COEF,
  output logic               oWE_A,
  output logic               oWE_B,
  output logic               oSOURCE_DATA,
  output logic               oSOURCE_CONT,
  output logic               oRDY,
  output logic               oDONE
);

  localparam int D     = depth(N_LOG2);
  localparam int L     = stage_len(N_LOG2, BFLY_LAT);
  localparam int T_BIT = $clog2(L + 1);

  fht_state_t        state;
  logic [ST_BIT-1:0] stage;
  logic [T_BIT-1:0]  t;
  logic              src_data;
  logic              src_cont;
  logic              done;

  logic              busy;
  logic              rd_en;
  logic              wr_en;
  logic [T_BIT-1:0]  u;
  logic [A_BIT-1:0]  rd_step;
  logic [A_BIT-1:0]  wr_step;
  logic [A_BIT-1:0]  rd_direct;
  logic [A_BIT-1:0]  rd_mirror;
  logic [A_BIT-1:0]  wr_direct;
  logic [A_BIT-1:0]  wr_mirror;
  logic              we;
  logic [SEC_BIT-1:0] wr_sector_unused;
  logic               wr_half_unused;
  logic [A_BIT-1:0]   wr_coef_unused;

  // Sequencer: abort wins over start and stage end; the final stage end raises done for one cycle.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state    <= FHT_IDLE;
      stage    <= {ST_BIT{1'b0}};
      t        <= {T_BIT{1'b0}};
      src_data <= 1'b0;
      src_cont <= 1'b0;
      done     <= 1'b0;
    end else if (iABORT) begin
      state    <= FHT_IDLE;
      stage    <= {ST_BIT{1'b0}};
      t        <= {T_BIT{1'b0}};
      src_data <= 1'b0;
      src_cont <= (state == FHT_IDLE);
      done     <= 1'b0;
    end else begin
      case (state)
        FHT_IDLE: begin
          done <= 1'b0;
          if (iSTART) begin
            state    <= FHT_RUN;
            stage    <= {ST_BIT{1'b0}};
            t        <= {T_BIT{1'b0}};
            src_cont <= 1'b0;
          end else begin
            src_cont <= 1'b1;
          end
        end
        FHT_RUN: begin
          src_cont <= 1'b0;
          if (t == T_BIT'(L - 1)) begin
            t <= {T_BIT{1'b0}};
            if (stage == ST_BIT'(N_LOG2 - 1)) begin
              state    <= FHT_IDLE;
              stage    <= {ST_BIT{1'b0}};
              src_data <= 1'b0;
              done     <= 1'b1;
            end else begin
              stage    <= stage + 1'b1;
              src_data <= ~src_data;
              done     <= 1'b0;
            end
          end else begin
            t    <= t + 1'b1;
            done <= 1'b0;
          end
        end
        default: begin
          state    <= FHT_IDLE;
          stage    <= {ST_BIT{1'b0}};
          t        <= {T_BIT{1'b0}};
          src_data <= 1'b0;
          src_cont <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state == FHT_RUN);
  assign rd_en   = busy && (t < T_BIT'(2 * D));
  assign wr_en   = busy && (t >= T_BIT'(BFLY_LAT)) && (t < T_BIT'(BFLY_LAT + 2 * D));
  assign u       = t - T_BIT'(BFLY_LAT);
  assign rd_step = A_BIT'(t >> 1);
  assign wr_step = A_BIT'(u >> 1);
  // Each step spans two cycles; the write lands on the second one.
  assign we      = wr_en && u[0];

  fht_addr_map #(.A_BIT(A_BIT), .SEC_BIT(SEC_BIT), .ST_BIT(ST_BIT)) u_rd_map (
    .step        (rd_step),
    .stage       (stage),
    .en          (rd_en),
    .sector      (oSECTOR),
    .second_half (o2ND_PART_SUBSEC),
    .direct      (rd_direct),
    .mirror      (rd_mirror),
    .coef        (oADDR_COEF)
  );

  fht_addr_map #(.A_BIT(A_BIT), .SEC_BIT(SEC_BIT), .ST_BIT(ST_BIT)) u_wr_map (
    .step        (wr_step),
    .stage       (stage),
    .en          (wr_en),
    .sector      (wr_sector_unused),
    .second_half (wr_half_unused),
    .direct      (wr_direct),
    .mirror      (wr_mirror),
    .coef        (wr_coef_unused)
  );

  assign oSTAGE        = stage;
  assign oST_ZERO      = busy && (stage == {ST_BIT{1'b0}});
  assign oST_LAST      = busy && (stage == ST_BIT'(N_LOG2 - 1));
  assign oADDR_RD_0    = rd_direct;
  assign oADDR_RD_2    = rd_direct;
  assign oADDR_RD_1    = rd_mirror;
  assign oADDR_RD_3    = rd_mirror;
  assign oADDR_WR      = wr_direct;
  assign oADDR_WR_BIAS = wr_mirror;
  assign oWE_A         = we && src_data;
  assign oWE_B         = we && !src_data;
  assign oSOURCE_DATA  = src_data;
  assign oSOURCE_CONT  = src_cont;
  assign oRDY          = !busy;
  assign oDONE         = done;

endmodule

// File: tb/tb_fht_control_gen.sv
// Bench for fht_control_gen at N_LOG2=5 and N_LOG2=10.
// A model built from elapsed-cycle arithmetic predicts every output on every cycle.
module tb_fht_control_gen;

  localparam int LAT = 6;

  logic clk;
  logic rst_n;
  logic start_a, abort_a, start_b, abort_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a_stage;  logic a_st_zero, a_st_last, a_second;  logic [3:0] a_sector;
  logic [2:0] a_rd0, a_rd1, a_rd2, a_rd3, a_wr, a_wr_bias, a_coef;
  logic a_we_a, a_we_b, a_src_data, a_src_cont, a_rdy, a_done;

  logic [3:0] b_stage;  logic b_st_zero, b_st_last, b_second;  logic [8:0] b_sector;
  logic [7:0] b_rd0, b_rd1, b_rd2, b_rd3, b_wr, b_wr_bias, b_coef;
  logic b_we_a, b_we_b, b_src_data, b_src_cont, b_rdy, b_done;

  fht_control_gen #(.N_LOG2(5), .BFLY_LAT(LAT)) dut_a (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start_a), .iABORT(abort_a),
    .oSTAGE(a_stage), .oST_ZERO(a_st_zero), .oST_LAST(a_st_last), .o2ND_PART_SUBSEC(a_second),
    .oSECTOR(a_sector), .oADDR_RD_0(a_rd0), .oADDR_RD_2(a_rd2), .oADDR_RD_1(a_rd1), .oADDR_RD_3(a_rd3),
    .oADDR_WR(a_wr), .oADDR_WR_BIAS(a_wr_bias), .oADDR_COEF(a_coef), .oWE_A(a_we_a), .oWE_B(a_we_b),
    .oSOURCE_DATA(a_src_data), .oSOURCE_CONT(a_src_cont), .oRDY(a_rdy), .oDONE(a_done)
  );

  fht_control_gen #(.N_LOG2(10), .BFLY_LAT(LAT)) dut_b (
    .iCLK(clk), .iRESET(rst_n), .iSTART(start_b), .iABORT(abort_b),
    .oSTAGE(b_stage), .oST_ZERO(b_st_zero), .oST_LAST(b_st_last), .o2ND_PART_SUBSEC(b_second),
    .oSECTOR(b_sector), .oADDR_RD_0(b_rd0), .oADDR_RD_2(b_rd2), .oADDR_RD_1(b_rd1), .oADDR_RD_3(b_rd3),
    .oADDR_WR(b_wr), .oADDR_WR_BIAS(b_wr_bias), .oADDR_COEF(b_coef), .oWE_A(b_we_a), .oWE_B(b_we_b),
    .oSOURCE_DATA(b_src_data), .oSOURCE_CONT(b_src_cont), .oRDY(b_rdy), .oDONE(b_done)
  );

  typedef struct {
    int stage, st_zero, st_last, second, sector, rd0, rd1, rd2, rd3;
    int wr, wr_bias, coef, we_a, we_b, src_data, src_cont, rdy, done;
  } obs_t;

  obs_t obs_a, obs_b;

  always_comb begin
    obs_a.stage = int'(a_stage);  obs_a.st_zero = int'(a_st_zero);  obs_a.st_last = int'(a_st_last);
    obs_a.second = int'(a_second); obs_a.sector = int'(a_sector);
    obs_a.rd0 = int'(a_rd0); obs_a.rd1 = int'(a_rd1); obs_a.rd2 = int'(a_rd2); obs_a.rd3 = int'(a_rd3);
    obs_a.wr = int'(a_wr); obs_a.wr_bias = int'(a_wr_bias); obs_a.coef = int'(a_coef);
    obs_a.we_a = int'(a_we_a); obs_a.we_b = int'(a_we_b); obs_a.src_data = int'(a_src_data);
    obs_a.src_cont = int'(a_src_cont); obs_a.rdy = int'(a_rdy); obs_a.done = int'(a_done);
  end

  always_comb begin
    obs_b.stage = int'(b_stage);  obs_b.st_zero = int'(b_st_zero);  obs_b.st_last = int'(b_st_last);
    obs_b.second = int'(b_second); obs_b.sector = int'(b_sector);
    obs_b.rd0 = int'(b_rd0); obs_b.rd1 = int'(b_rd1); obs_b.rd2 = int'(b_rd2); obs_b.rd3 = int'(b_rd3);
    obs_b.wr = int'(b_wr); obs_b.wr_bias = int'(b_wr_bias); obs_b.coef = int'(b_coef);
    obs_b.we_a = int'(b_we_a); obs_b.we_b = int'(b_we_b); obs_b.src_data = int'(b_src_data);
    obs_b.src_cont = int'(b_src_cont); obs_b.rdy = int'(b_rdy); obs_b.done = int'(b_done);
  end

  int errors = 0;
  int checks = 0;
  int cur_n  = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL n=%0d %s: got %0d expected %0d", cur_n, tag, got, want);
    end
  endtask

  // Model state per instance (0: N_LOG2=5, 1: N_LOG2=10): busy flag and cycles elapsed since start.
  int nlog[2] = '{5, 10};
  int busy_m[2], c_m[2], done_m[2], cont_m[2];

  function automatic obs_t predict(input int n, input int busy, input int c, input int done, input int cont);
    obs_t e;
    int d, l, s, t, p, slen, k, o, u, q;
    e = '{default: 0};
    d = 2 ** (n - 2);
    l = 2 * d + LAT;
    s = (busy != 0) ? c / l : 0;
    t = (busy != 0) ? c % l : 0;
    e.stage    = s;
    e.st_zero  = (busy != 0 && s == 0) ? 1 : 0;
    e.st_last  = (busy != 0 && s == n - 1) ? 1 : 0;
    e.rdy      = (busy != 0) ? 0 : 1;
    e.done     = done;
    e.src_cont = cont;
    e.src_data = (busy != 0) ? s % 2 : 0;
    slen = d / (2 ** ((s > 1) ? s - 1 : 0));
    if (slen < 1) slen = 1;
    if (busy != 0 && t < 2 * d) begin
      p = t / 2;  k = p / slen;  o = p % slen;
      e.rd0 = p;  e.rd2 = p;
      e.rd1 = (k == 0) ? p : k * slen + ((slen - o) % slen);
      e.rd3 = e.rd1;
      e.sector = k;
      e.second = (o >= slen / 2) ? 1 : 0;
      e.coef = (s == 0) ? 0 : (o * (2 ** (s - 1))) % d;
    end
    u = t - LAT;
    if (busy != 0 && u >= 0 && u < 2 * d) begin
      q = u / 2;  k = q / slen;  o = q % slen;
      e.wr = q;
      e.wr_bias = (k == 0) ? q : k * slen + ((slen - o) % slen);
      if (u % 2 == 1) begin
        if (s % 2 == 0) e.we_b = 1;
        else e.we_a = 1;
      end
    end
    return e;
  endfunction

  task automatic step_model(input int i, input logic st, input logic ab);
    int total, rdy_old, accept;
    total   = nlog[i] * (2 * (2 ** (nlog[i] - 2)) + LAT);
    rdy_old = (busy_m[i] != 0) ? 0 : 1;
    accept  = (ab == 1'b0 && st == 1'b1 && busy_m[i] == 0) ? 1 : 0;
    cont_m[i] = (accept != 0) ? 0 : rdy_old;
    done_m[i] = 0;
    if (ab == 1'b1) begin
      busy_m[i] = 0;  c_m[i] = 0;
    end else if (busy_m[i] == 0) begin
      if (accept != 0) begin busy_m[i] = 1; c_m[i] = 0; end
    end else begin
      c_m[i] = c_m[i] + 1;
      if (c_m[i] == total) begin busy_m[i] = 0; c_m[i] = 0; done_m[i] = 1; end
    end
  endtask

  task automatic compare(input int i, input obs_t o);
    obs_t e;
    e = predict(nlog[i], busy_m[i], c_m[i], done_m[i], cont_m[i]);
    cur_n = nlog[i];
    check_eq("stage", o.stage, e.stage);       check_eq("st_zero", o.st_zero, e.st_zero);
    check_eq("st_last", o.st_last, e.st_last); check_eq("2nd_part", o.second, e.second);
    check_eq("sector", o.sector, e.sector);    check_eq("rd0", o.rd0, e.rd0);
    check_eq("rd1", o.rd1, e.rd1);             check_eq("rd2", o.rd2, e.rd2);
    check_eq("rd3", o.rd3, e.rd3);             check_eq("wr", o.wr, e.wr);
    check_eq("wr_bias", o.wr_bias, e.wr_bias); check_eq("coef", o.coef, e.coef);
    check_eq("we_a", o.we_a, e.we_a);          check_eq("we_b", o.we_b, e.we_b);
    check_eq("src_data", o.src_data, e.src_data);
    check_eq("src_cont", o.src_cont, e.src_cont);
    check_eq("rdy", o.rdy, e.rdy);             check_eq("done", o.done, e.done);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step_model(0, start_a, abort_a);
    step_model(1, start_b, abort_b);
    compare(0, obs_a);
    compare(1, obs_b);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      busy_m[i] = 0; c_m[i] = 0; done_m[i] = 0; cont_m[i] = 0;
    end
    compare(0, obs_a);
    compare(1, obs_b);
    #1;
    rst_n = 1'b1;
  endtask

  int low_cycles, dones, toggles, prev_src, we_b0, we_a0, finished;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy_m[i] = 0; c_m[i] = 0; done_m[i] = 0; cont_m[i] = 0;
    end
    #3;
    compare(0, obs_a);
    compare(1, obs_b);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Full transform on both sizes, with stray start pulses on the large one.
    start_a = 1'b1; start_b = 1'b1;
    low_cycles = 0; dones = 0; toggles = 0; prev_src = 0; we_b0 = 0; we_a0 = 0; finished = 0;
    for (int n = 0; n < 6000 && finished == 0; n++) begin
      tick();
      start_a = 1'b0;
      start_b = (b_rdy == 1'b0 && $urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
      if (b_rdy == 1'b0) low_cycles++;
      if (b_done == 1'b1) begin dones++; finished = 1; start_b = 1'b0; end
      if (int'(b_src_data) != prev_src) toggles++;
      prev_src = int'(b_src_data);
      if (a_rdy == 1'b0 && a_stage == 4'd0) begin
        we_b0 += int'(a_we_b);
        we_a0 += int'(a_we_a);
      end
    end
    repeat (3) begin
      tick();
      dones += int'(b_done);
    end
    cur_n = 10;
    check_eq("run_finished", finished, 1);
    check_eq("rdy_low_cycles", low_cycles, 10 * (2 * (2 ** 8) + LAT));
    check_eq("done_pulses", dones, 1);
    check_eq("src_toggles", toggles, 10);
    check_eq("src_final", int'(b_src_data), 0);
    cur_n = 5;
    check_eq("stage0_we_b_pulses", we_b0, 8);
    check_eq("stage0_we_a_pulses", we_a0, 0);

    // Abort at stage 3, t=9, then a clean rerun.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3 * 22 + 9) tick();
    check_eq("pre_abort_stage", int'(a_stage), 3);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_eq("abort_rdy", int'(a_rdy), 1);
    check_eq("abort_we", int'(a_we_a) + int'(a_we_b), 0);
    check_eq("abort_src", int'(a_src_data), 0);
    check_eq("abort_done", int'(a_done), 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    low_cycles = 0;
    for (int n = 0; n < 300 && a_rdy == 1'b0; n++) begin
      low_cycles++;
      tick();
    end
    check_eq("rerun_low_cycles", low_cycles, 5 * 22);
    check_eq("rerun_done", int'(a_done), 1);

    // Start together with abort while idle stays idle.
    tick();
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check_eq("start_abort_idle", int'(a_rdy), 1);

    // Async reset in the middle of a run.
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    repeat (40) tick();
    async_reset();
    tick();

    // Randomized start/abort/reset traffic.
    for (int n = 0; n < 4000; n++) begin
      start_a = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
      start_b = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
      abort_a = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      abort_b = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
      tick();
      if ($urandom_range(0, 1999) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
